// File: rtl/axil_xbar_pkg.sv
// Shared constants for the AXI4-Lite crossbar: FSM state encodings, response codes
// and an index-width helper that stays at least one bit wide for single-entry ports.
package axil_xbar_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD     = 3'd1;
    localparam logic [2:0] ST_WR     = 3'd2;
    localparam logic [2:0] ST_DERR_R = 3'd3;
    localparam logic [2:0] ST_DERR_B = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_xbar_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr (wrapping)
// wins; the pointer itself is owned and advanced by the crossbar.
module rr_arbiter
    import axil_xbar_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        any   = |req;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found                       = 1'b1;
                gnt[(int'(ptr) + k) % N]    = 1'b1;
                idx                         = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/axil_xbar.sv
// AXI4-Lite crossbar: NM masters share NS external slaves, one transaction at a time,
// round-robin between masters, with an internal DECERR responder for unmapped addresses.
module axil_xbar
    import axil_xbar_pkg::*;
#(
    parameter int NM = 2,
    parameter int NS = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [NS*AW-1:0] SLV_BASE = {32'h1000_0000, 32'h8000_0000},
    parameter logic [NS*AW-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFF00_0000}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NM*AW-1:0]     m_araddr,
    input  logic [NM-1:0]        m_arvalid,
    output logic [NM-1:0]        m_arready,
    output logic [NM*DW-1:0]     m_rdata,
    output logic [NM*2-1:0]      m_rresp,
    output logic [NM-1:0]        m_rvalid,
    input  logic [NM-1:0]        m_rready,
    input  logic [NM*AW-1:0]     m_awaddr,
    input  logic [NM-1:0]        m_awvalid,
    output logic [NM-1:0]        m_awready,
    input  logic [NM*DW-1:0]     m_wdata,
    input  logic [NM*DW/8-1:0]   m_wstrb,
    input  logic [NM-1:0]        m_wvalid,
    output logic [NM-1:0]        m_wready,
    output logic [NM*2-1:0]      m_bresp,
    output logic [NM-1:0]        m_bvalid,
    input  logic [NM-1:0]        m_bready,
    output logic [NS*AW-1:0]     s_araddr,
    output logic [NS-1:0]        s_arvalid,
    input  logic [NS-1:0]        s_arready,
    input  logic [NS*DW-1:0]     s_rdata,
    input  logic [NS*2-1:0]      s_rresp,
    input  logic [NS-1:0]        s_rvalid,
    output logic [NS-1:0]        s_rready,
    output logic [NS*AW-1:0]     s_awaddr,
    output logic [NS-1:0]        s_awvalid,
    input  logic [NS-1:0]        s_awready,
    output logic [NS*DW-1:0]     s_wdata,
    output logic [NS*DW/8-1:0]   s_wstrb,
    output logic [NS-1:0]        s_wvalid,
    input  logic [NS-1:0]        s_wready,
    input  logic [NS*2-1:0]      s_bresp,
    input  logic [NS-1:0]        s_bvalid,
    output logic [NS-1:0]        s_bready,
    output logic [2:0]           dbg_state
);

    localparam int MW = idx_w(NM);
    localparam int SW = idx_w(NS);
    localparam int SB = DW / 8;

    // Handshakes: a beat transfers on a clock edge where valid and ready are both 1;
    // valid never waits on ready, and all routed channels are pure wires in RD/WR.

    state_t         state;
    logic [MW-1:0]  gnt_m;
    logic [MW-1:0]  rr_ptr;
    logic [SW-1:0]  gnt_s;
    logic           ar_done;
    logic           aw_done;
    logic           w_done;

    logic [NM-1:0]  req;
    logic [NM-1:0]  arb_gnt;
    logic [MW-1:0]  arb_idx;
    logic           arb_any;
    logic           is_rd;
    logic [AW-1:0]  dec_addr;
    logic           hit;
    logic [SW-1:0]  hit_idx;
    logic           done;
    logic [MW-1:0]  next_ptr;

    assign req       = m_arvalid | m_awvalid;
    assign dbg_state = state;

    rr_arbiter #(.N(NM)) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Read wins over write inside the granted master.
    assign is_rd    = |(arb_gnt & m_arvalid);
    assign dec_addr = is_rd ? m_araddr[arb_idx*AW +: AW] : m_awaddr[arb_idx*AW +: AW];

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((dec_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    assign next_ptr = (NM == 1 || gnt_m == MW'(NM - 1)) ? '0 : gnt_m + 1'b1;

    always_comb begin
        done = 1'b0;
        case (state)
            ST_RD:     done = s_rvalid[gnt_s] & s_rready[gnt_s];
            ST_WR:     done = s_bvalid[gnt_s] & s_bready[gnt_s];
            ST_DERR_R: done = ar_done & m_rready[gnt_m];
            ST_DERR_B: done = aw_done & w_done & m_bready[gnt_m];
            default:   done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            gnt_m   <= '0;
            gnt_s   <= '0;
            rr_ptr  <= '0;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == ST_IDLE) begin
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (arb_any) begin
                gnt_m <= arb_idx;
                gnt_s <= hit_idx;
                if (hit) state <= is_rd ? ST_RD : ST_WR;
                else     state <= is_rd ? ST_DERR_R : ST_DERR_B;
            end
        end else begin
            if (m_arvalid[gnt_m] & m_arready[gnt_m]) ar_done <= 1'b1;
            if (m_awvalid[gnt_m] & m_awready[gnt_m]) aw_done <= 1'b1;
            if (m_wvalid[gnt_m] & m_wready[gnt_m])   w_done  <= 1'b1;
            if (done) begin
                state  <= ST_IDLE;
                rr_ptr <= next_ptr;
            end
        end
    end

    always_comb begin
        m_arready = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rvalid  = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bresp   = '0;
        m_bvalid  = '0;
        s_araddr  = '0;
        s_arvalid = '0;
        s_rready  = '0;
        s_awaddr  = '0;
        s_awvalid = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = '0;
        s_bready  = '0;
        case (state)
            ST_RD: begin
                s_araddr[gnt_s*AW +: AW] = m_araddr[gnt_m*AW +: AW];
                s_arvalid[gnt_s]         = m_arvalid[gnt_m];
                m_arready[gnt_m]         = s_arready[gnt_s];
                m_rdata[gnt_m*DW +: DW]  = s_rdata[gnt_s*DW +: DW];
                m_rresp[gnt_m*2 +: 2]    = s_rresp[gnt_s*2 +: 2];
                m_rvalid[gnt_m]          = s_rvalid[gnt_s];
                s_rready[gnt_s]          = m_rready[gnt_m];
            end
            ST_WR: begin
                s_awaddr[gnt_s*AW +: AW] = m_awaddr[gnt_m*AW +: AW];
                s_awvalid[gnt_s]         = m_awvalid[gnt_m];
                m_awready[gnt_m]         = s_awready[gnt_s];
                s_wdata[gnt_s*DW +: DW]  = m_wdata[gnt_m*DW +: DW];
                s_wstrb[gnt_s*SB +: SB]  = m_wstrb[gnt_m*SB +: SB];
                s_wvalid[gnt_s]          = m_wvalid[gnt_m];
                m_wready[gnt_m]          = s_wready[gnt_s];
                m_bresp[gnt_m*2 +: 2]    = s_bresp[gnt_s*2 +: 2];
                m_bvalid[gnt_m]          = s_bvalid[gnt_s];
                s_bready[gnt_s]          = m_bready[gnt_m];
            end
            ST_DERR_R: begin
                m_arready[gnt_m]      = m_arvalid[gnt_m] & ~ar_done;
                m_rvalid[gnt_m]       = ar_done;
                m_rresp[gnt_m*2 +: 2] = ar_done ? RESP_DECERR : RESP_OKAY;
            end
            ST_DERR_B: begin
                m_awready[gnt_m]      = m_awvalid[gnt_m] & ~aw_done;
                m_wready[gnt_m]       = m_wvalid[gnt_m] & ~w_done;
                m_bvalid[gnt_m]       = aw_done & w_done;
                m_bresp[gnt_m*2 +: 2] = (aw_done & w_done) ? RESP_DECERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

endmodule
